// File: rtl/dht11_read_scheduler.sv
// DHT11 read scheduler: paces start pulses to the bit-level read engine, times out
// hung reads, verifies the frame checksum, retries failures and holds the last good sample.
module dht11_read_scheduler #(
  parameter int PERIOD_CYC  = 100_000_000,
  parameter int MIN_GAP_CYC = 50_000_000,
  parameter int TIMEOUT_CYC = 10_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        auto_en,
  input  logic        trig,
  output logic        eng_start,
  input  logic        eng_done,
  input  logic [39:0] eng_data,
  output logic [7:0]  hum_int,
  output logic [7:0]  hum_dec,
  output logic [7:0]  temp_int,
  output logic [7:0]  temp_dec,
  output logic        data_valid,
  output logic        new_sample,
  output logic        read_fail,
  output logic [7:0]  err_cnt,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;

  localparam int GW = (MIN_GAP_CYC > 1) ? $clog2(MIN_GAP_CYC + 1) : 1;
  localparam int PW = (PERIOD_CYC > 2) ? $clog2(PERIOD_CYC) : 1;
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [GW-1:0] GAP_MAX     = GW'(MIN_GAP_CYC);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]    RETRY_MAX   = 3'(MAX_RETRY);

  logic [2:0]    state_q,   state_d;
  logic [GW-1:0] gap_q,     gap_d;
  logic [PW-1:0] period_q,  period_d;
  logic [TW-1:0] tmo_q,     tmo_d;
  logic          pending_q, pending_d;
  logic [2:0]    retry_q,   retry_d;
  logic [39:0]   frame_q,   frame_d;
  logic [31:0]   sample_q,  sample_d;
  logic          valid_q,   valid_d;
  logic          new_q,     new_d;
  logic          fail_q,    fail_d;
  logic [7:0]    err_q,     err_d;

  logic          period_tick;
  logic          attempt_fail;
  logic [7:0]    csum;
  logic          csum_ok;

  // 8-bit wraparound sum of the four data bytes must equal the checksum byte.
  assign csum    = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
  assign csum_ok = (csum == frame_q[7:0]);

  // Engine handshake: eng_start is a single-cycle request issued only from ISSUE;
  // eng_done is a single-cycle completion accepted only in WAIT_DONE, with
  // eng_data qualified by eng_done in that same cycle. Any other eng_done is dropped.
  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    period_d     = period_q;
    tmo_d        = tmo_q;
    pending_d    = pending_q;
    retry_d      = retry_q;
    frame_d      = frame_q;
    sample_d     = sample_q;
    valid_d      = valid_q;
    new_d        = 1'b0;
    fail_d       = 1'b0;
    err_d        = err_q;
    period_tick  = 1'b0;
    attempt_fail = 1'b0;

    if (!auto_en) begin
      period_d = '0;
    end else if (state_q != S_ISSUE) begin
      if (period_q == PERIOD_LAST) begin
        period_d    = '0;
        period_tick = 1'b1;
      end else begin
        period_d = period_q + 1'b1;
      end
    end

    if (trig || period_tick) begin
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (gap_q != GAP_MAX) begin
          gap_d = gap_q + 1'b1;
        end
        // Launch consumes the merged request; only a trig in this very cycle survives.
        if (pending_q && (gap_q == GAP_MAX)) begin
          state_d   = S_ISSUE;
          pending_d = trig;
          period_d  = '0;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done) begin
          frame_d = eng_data;
          state_d = S_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          attempt_fail = 1'b1;
          gap_d        = '0;
          state_d      = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_CHECK: begin
        gap_d   = '0;
        state_d = S_IDLE;
        if (csum_ok) begin
          sample_d = frame_q[39:8];
          valid_d  = 1'b1;
          new_d    = 1'b1;
          retry_d  = '0;
        end else begin
          attempt_fail = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (attempt_fail) begin
      if (err_q != 8'hFF) begin
        err_d = err_q + 1'b1;
      end
      if (retry_q < RETRY_MAX) begin
        retry_d   = retry_q + 1'b1;
        pending_d = 1'b1;
      end else begin
        fail_d  = 1'b1;
        retry_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gap_q     <= '0;
      period_q  <= '0;
      tmo_q     <= '0;
      pending_q <= 1'b0;
      retry_q   <= '0;
      frame_q   <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      new_q     <= 1'b0;
      fail_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      period_q  <= period_d;
      tmo_q     <= tmo_d;
      pending_q <= pending_d;
      retry_q   <= retry_d;
      frame_q   <= frame_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      new_q     <= new_d;
      fail_q    <= fail_d;
      err_q     <= err_d;
    end
  end

  assign eng_start  = (state_q == S_ISSUE);
  assign hum_int    = sample_q[31:24];
  assign hum_dec    = sample_q[23:16];
  assign temp_int   = sample_q[15:8];
  assign temp_dec   = sample_q[7:0];
  assign data_valid = valid_q;
  assign new_sample = new_q;
  assign read_fail  = fail_q;
  assign err_cnt    = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_dht11_read_scheduler.sv
// Bench for dht11_read_scheduler: directed scenarios plus randomized reads, checked
// against a transaction-level model of the scheduling, retry and sample-holding rules.
module tb_dht11_read_scheduler;

  localparam int PERIOD    = 1000;
  localparam int MIN_GAP   = 100;
  localparam int TIMEOUT   = 200;
  localparam int MAX_RETRY = 2;

  localparam logic [39:0] GOOD_A = 40'h37_00_18_00_4F;
  localparam logic [39:0] BAD_A  = 40'h37_00_18_00_50;
  localparam logic [39:0] GOOD_B = 40'h11_22_33_44_AA;
  localparam logic [39:0] GOOD_C = 40'h2A_05_16_03_48;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        auto_en = 1'b0;
  logic        trig = 1'b0;
  logic        eng_done = 1'b0;
  logic [39:0] eng_data = '0;
  logic        eng_start;
  logic [7:0]  hum_int, hum_dec, temp_int, temp_dec;
  logic        data_valid, new_sample, read_fail;
  logic [7:0]  err_cnt;
  logic [2:0]  state_dbg;

  dht11_read_scheduler #(
    .PERIOD_CYC (PERIOD),
    .MIN_GAP_CYC(MIN_GAP),
    .TIMEOUT_CYC(TIMEOUT),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .auto_en   (auto_en),
    .trig      (trig),
    .eng_start (eng_start),
    .eng_done  (eng_done),
    .eng_data  (eng_data),
    .hum_int   (hum_int),
    .hum_dec   (hum_dec),
    .temp_int  (temp_int),
    .temp_dec  (temp_dec),
    .data_valid(data_valid),
    .new_sample(new_sample),
    .read_fail (read_fail),
    .err_cnt   (err_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_sample;
  int          exp_err;
  bit          exp_valid;
  int          m_retry;
  bit          retry_pend;
  bit          exp_fail_now;
  int          exp_fail_total = 0;
  int          fail_seen = 0;
  int          t_idle;
  int          rel;

  function automatic bit frame_ok(input logic [39:0] f);
    int s;
    s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    return (s % 256) == int'(f[7:0]);
  endfunction

  function automatic logic [39:0] make_frame(input bit good);
    logic [31:0] d;
    logic [7:0]  cs;
    int          s;
    d  = $urandom;
    s  = int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0]);
    cs = 8'(s % 256);
    if (!good) cs = cs + 8'($urandom_range(1, 255));
    return {d, cs};
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    exp_sample = '0;
    exp_err    = 0;
    exp_valid  = 1'b0;
    m_retry    = 0;
    retry_pend = 1'b0;
  endfunction

  // One attempt outcome: good frames update the held sample; failures count,
  // then either queue a retry or, once retries are used up, signal read_fail.
  function automatic void model_result(input bit ok, input logic [39:0] f);
    exp_fail_now = 1'b0;
    if (ok) begin
      exp_sample = f[39:8];
      exp_valid  = 1'b1;
      m_retry    = 0;
      retry_pend = 1'b0;
      exp_q.push_back(f[39:8]);
    end else begin
      if (exp_err < 255) exp_err++;
      if (m_retry < MAX_RETRY) begin
        m_retry++;
        retry_pend = 1'b1;
      end else begin
        m_retry    = 0;
        retry_pend = 1'b0;
        exp_fail_now = 1'b1;
        exp_fail_total++;
      end
    end
  endfunction

  // Scoreboard: every new_sample pulse must match the oldest expected sample.
  always @(negedge clk) begin
    if (!rst) begin
      if (read_fail) fail_seen++;
      if (new_sample) begin
        if (exp_q.size() == 0) check("new_sample_unexpected", 1, 0);
        else check("sb_sample", {hum_int, hum_dec, temp_int, temp_dec}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1;
    trig = 1'b0;
    eng_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    t_idle = cyc;
    model_reset();
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      if (eng_start) at = cyc;
      else @(negedge clk);
    end
    if (at < 0) check("start_seen", 0, 1);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int starts;
    starts = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (eng_start) starts++;
    end
    check(tag, starts, 0);
  endtask

  int last_start = -1;

  // Runs one engine transaction; called at a negedge. The expected launch cycle is
  // the later of "gap elapsed since the last transaction end" and "request + 2".
  task automatic do_txn(input bit no_reply, input logic [39:0] f, input int lat,
                        input bit send_trig, input bit chk_start, input int n_trig_wait);
    int s, exp_s, trig_cyc;
    bit ok;
    ok = 1'b0;
    exp_s = t_idle + MIN_GAP + 1;
    if (send_trig) begin
      trig_cyc = cyc;
      pulse_trig();
      if (trig_cyc + 2 > exp_s) exp_s = trig_cyc + 2;
    end
    wait_start(PERIOD + 600, s);
    if (s < 0) return;
    if (chk_start) check("start_cycle", s, exp_s);
    last_start = s;
    check("state_issue", state_dbg, 1);
    @(negedge clk);
    check("start_one_cycle", eng_start, 0);
    check("state_wait", state_dbg, 2);
    if (!no_reply) begin
      for (int i = 0; i < lat - 1; i++) begin
        trig = (i < 2 * n_trig_wait) && (i % 2 == 0);
        @(negedge clk);
      end
      trig = 1'b0;
      ok = frame_ok(f);
      model_result(ok, f);
      eng_done = 1'b1;
      eng_data = f;
      @(negedge clk);
      eng_done = 1'b0;
      eng_data = {8'($urandom), $urandom};
      check("state_check", state_dbg, 3);
      @(negedge clk);
    end else begin
      model_result(1'b0, f);
      repeat (TIMEOUT - 1) @(negedge clk);
      check("state_wait_last", state_dbg, 2);
      @(negedge clk);
    end
    t_idle = cyc;
    check("state_idle", state_dbg, 0);
    check("new_sample", new_sample, ok);
    check("read_fail", read_fail, exp_fail_now);
    check("err_cnt", err_cnt, exp_err);
    check("data_valid", data_valid, exp_valid);
    check("sample", {hum_int, hum_dec, temp_int, temp_dec}, exp_sample);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s1, s2, s3;
    repeat (3) @(negedge clk);
    apply_reset();
    check("rst_state", state_dbg, 0);
    check("rst_start", eng_start, 0);
    check("rst_valid", data_valid, 0);
    check("rst_err", err_cnt, 0);
    check("rst_sample", {hum_int, hum_dec, temp_int, temp_dec}, 0);

    // First read on manual trigger waits out the post-reset gap.
    repeat (10) @(negedge clk);
    do_txn(1'b0, GOOD_A, 50, 1'b1, 1'b1, 0);
    check("t1_hum_int", hum_int, 8'h37);
    check("t1_temp_int", temp_int, 8'h18);

    // Periodic reads.
    auto_en = 1'b1;
    do_txn(1'b0, GOOD_A, 50, 1'b0, 1'b0, 0);
    s1 = last_start;
    do_txn(1'b0, GOOD_A, 50, 1'b0, 1'b0, 0);
    s2 = last_start;
    do_txn(1'b0, GOOD_A, 50, 1'b0, 1'b0, 0);
    s3 = last_start;
    auto_en = 1'b0;
    check("auto_spacing_1", (s2 - s1 >= PERIOD) && (s2 - s1 <= PERIOD + 2), 1);
    check("auto_spacing_2", (s3 - s2 >= PERIOD) && (s3 - s2 <= PERIOD + 2), 1);
    expect_quiet("auto_off_quiet", PERIOD + 200);

    // Checksum failures exhaust the retries.
    do_txn(1'b0, BAD_A, 50, 1'b1, 1'b1, 0);
    do_txn(1'b0, BAD_A, 50, 1'b0, 1'b1, 0);
    do_txn(1'b0, BAD_A, 50, 1'b0, 1'b1, 0);
    check("t3_err", err_cnt, 3);
    check("t3_hum_int", hum_int, 8'h37);

    // Engine never answers; then a late eng_done in IDLE is ignored.
    do_txn(1'b1, GOOD_B, 0, 1'b1, 1'b1, 0);
    do_txn(1'b1, GOOD_B, 0, 1'b0, 1'b1, 0);
    do_txn(1'b1, GOOD_B, 0, 1'b0, 1'b1, 0);
    eng_done = 1'b1;
    eng_data = GOOD_B;
    @(negedge clk);
    eng_done = 1'b0;
    @(negedge clk);
    check("late_done_state", state_dbg, 0);
    check("late_done_sample", {hum_int, hum_dec, temp_int, temp_dec}, exp_sample);
    check("late_done_err", err_cnt, 6);

    // Merged triggers during WAIT_DONE, then eng_done on the timeout cycle.
    do_txn(1'b0, GOOD_C, 60, 1'b1, 1'b1, 3);
    do_txn(1'b0, GOOD_A, TIMEOUT, 1'b0, 1'b1, 0);
    check("coincident_err", err_cnt, 6);
    expect_quiet("merged_trig_quiet", 400);

    // Reset in the middle of WAIT_DONE.
    begin
      int s;
      pulse_trig();
      wait_start(400, s);
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      model_reset();
      check("midrst_state", state_dbg, 0);
      check("midrst_valid", data_valid, 0);
      check("midrst_err", err_cnt, 0);
      check("midrst_sample", {hum_int, hum_dec, temp_int, temp_dec}, 0);
      check("midrst_pulses", {eng_start, new_sample, read_fail}, 0);
      rst = 1'b0;
      rel = cyc;
      t_idle = cyc;
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      repeat (3) @(negedge clk);
      eng_done = 1'b1;
      eng_data = GOOD_B;
      @(negedge clk);
      eng_done = 1'b0;
      @(negedge clk);
      check("postrst_done_ignored", {hum_int, hum_dec, temp_int, temp_dec}, 0);
      check("postrst_valid", data_valid, 0);
      do_txn(1'b0, GOOD_C, 30, 1'b0, 1'b1, 0);
      check("postrst_start_delay", last_start - rel, MIN_GAP + 1);
    end

    // Randomized reads: random frames, latencies and timeouts.
    for (int k = 0; k < 10; k++) begin
      logic [39:0] f;
      bit to;
      int lat;
      f   = make_frame($urandom_range(0, 9) < 6);
      to  = ($urandom_range(0, 4) == 0);
      lat = $urandom_range(1, TIMEOUT);
      do_txn(to, f, lat, !retry_pend, 1'b1, 0);
    end

    @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("read_fail_total", fail_seen, exp_fail_total);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global safety bound.
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dht11_read_scheduler.md
Name: dht11_read_scheduler

Overview:
Controller that sequences the DHT11 bit-level read engine. It issues start pulses periodically and on demand, and enforces the sensor's minimum inter-read gap. It times out hung transactions, verifies the checksum, retries failed reads, and holds the last good sample for the display/UART consumers. It sits between the engine (start/done/40-bit frame) and the application logic.

Parameters:
PERIOD_CYC, 100_000_000, auto-read period in clk cycles (2 s at 50 MHz)
MIN_GAP_CYC, 50_000_000, minimum cycles from transaction end to next start (1 s)
TIMEOUT_CYC, 10_000_000, max cycles from eng_start to eng_done (200 ms)
MAX_RETRY, 3, retries after a failed read before declaring failure (1..7)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-high
auto_en  in  1  1 = periodic reads enabled
trig  in  1  single-cycle manual read request
eng_start  out  1  one-cycle start pulse to read engine
eng_done  in  1  one-cycle pulse, engine finished a frame
eng_data  in  40  frame: [39:32] hum_int, [31:24] hum_dec, [23:16] temp_int, [15:8] temp_dec, [7:0] checksum
hum_int, hum_dec, temp_int, temp_dec  out  8 each  last good sample
data_valid  out  1  sticky: at least one good sample since reset
new_sample  out  1  one-cycle pulse on a good-sample update
read_fail  out  1  one-cycle pulse when retries are exhausted
err_cnt  out  8  saturating count of failed attempts (timeouts plus checksum errors)
state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; all outputs 0; gap_cnt=0, period_cnt=0, retry=0, pending=0. Applies mid-transaction; a late eng_done after reset is ignored.
- States and encoding: IDLE=0, ISSUE=1, WAIT_DONE=2, CHECK=3.
- gap_cnt: saturates at MIN_GAP_CYC; cleared on CHECK exit and on timeout; counts only in IDLE.
- period_cnt: counts while auto_en=1 and state != ISSUE.
  - On reaching PERIOD_CYC-1, sets pending and wraps to 0.
  - Cleared on ISSUE entry.
  - Held at 0 while auto_en=0.
- pending: set by trig (any state) or by the period tick; cleared on ISSUE entry. It is one-deep: extra requests merge.
- IDLE -> ISSUE when pending=1 and gap_cnt==MIN_GAP_CYC. A first read therefore waits MIN_GAP_CYC after reset.
- ISSUE: eng_start=1 for exactly this one cycle; timeout counter cleared; -> WAIT_DONE.
- WAIT_DONE:
  - eng_done=1: latch eng_data, -> CHECK.
  - Timeout counter reaches TIMEOUT_CYC-1 without eng_done: treated as a failed attempt (see Failure below), -> IDLE.
  - eng_done and timeout in the same cycle: eng_done wins.
- CHECK (one cycle): good when (b4+b3+b2+b1) mod 256 == b0, using 8-bit wraparound addition.
  - Good: the four data outputs load on the CHECK exit edge; new_sample pulses one cycle (the IDLE cycle); data_valid=1; retry=0; -> IDLE.
  - Bad: Failure path, -> IDLE.
- Failure:
  - err_cnt increments, saturating at 255.
  - If retry < MAX_RETRY: retry++ and pending=1, so the retry issues after MIN_GAP_CYC.
  - Else: read_fail pulses one cycle, retry=0, and outputs and data_valid are held.
- eng_done outside WAIT_DONE is ignored.
- trig during WAIT_DONE or CHECK is latched as pending and serviced after the gap.
- Latency: ISSUE to data out = engine time + 2 cycles (CHECK, then outputs visible in IDLE).

Test Plan (override PERIOD_CYC=1000, MIN_GAP_CYC=100, TIMEOUT_CYC=200, MAX_RETRY=2):
1. Reset release, auto_en=0, trig at cycle 10 -> eng_start single pulse at cycle 101 after reset; engine model returns 40'h37_00_18_00_4F 50 cycles later -> hum_int=0x37, temp_int=0x18, data_valid=1, new_sample one pulse; err_cnt=0.
2. auto_en=1, engine always answers 40'h37_00_18_00_4F -> eng_start pulses repeat every 1000 cycles (gap satisfied); exactly one new_sample per transaction.
3. Engine returns 40'h37_00_18_00_50 three times -> three eng_start pulses spaced >=100 idle cycles; err_cnt=3; read_fail one pulse after the third; outputs keep the prior good sample.
4. Engine never answers -> WAIT_DONE exits after 200 cycles; retry issues after the 100-cycle gap; after 3 timeouts read_fail pulses; a late eng_done in IDLE changes nothing.
5. Three trig pulses during one WAIT_DONE -> exactly one further transaction after completion plus the gap; eng_done coincident with the timeout cycle -> sample accepted, err_cnt unchanged.
6. rst=1 asserted during WAIT_DONE -> next cycle state_dbg=0, all outputs 0, data_valid=0; a subsequent eng_done is ignored; the first new eng_start comes no earlier than 101 cycles after rst deasserts with trig.
